// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the SPI transaction sequencer.
// Provides the FSM state enum, the default TX entry struct and width helpers.
package spi_pkg;

  localparam int SPI_DW       = 8;
  localparam int SPI_PERI_CNT = 4;
  localparam int SPI_PW       = $clog2(SPI_PERI_CNT);

  typedef struct packed {
    logic [SPI_PW-1:0] peri;
    logic              last;
    logic [SPI_DW-1:0] data;
  } spi_tx_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    GAP
  } spi_seq_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-based FIFO with show-ahead read data (zero when empty).
// Ports: clk, sync_rst, push/wr_data, pop/rd_data, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW + 1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: feeds queued bytes to the SPI controller with CS framing.
// Ports: tx_* command stream in, rx_* byte stream out, start/data/sel/end to controller, busy.
module spi_txn_sequencer
  import spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH     = SPI_DW,
  parameter int PERI_CNT           = SPI_PERI_CNT,
  parameter int FIFO_DEPTH         = 4,
  parameter int MAX_BYTES_PER_CS   = 2,
  parameter int CS_INACTIVE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        sync_rst,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [SPI_DATA_WIDTH-1:0]   tx_data,
  input  logic [$clog2(PERI_CNT)-1:0] tx_peri,
  input  logic                        tx_last,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [SPI_DATA_WIDTH-1:0]   rx_data,
  output logic                        start_txn,
  output logic [SPI_DATA_WIDTH-1:0]   parallel_wr_data,
  output logic [PERI_CNT-1:0]         p_sel_one_cold,
  input  logic                        end_txn,
  input  logic [SPI_DATA_WIDTH-1:0]   ctrl_rx_data,
  output logic                        busy
);

  localparam int PW = $clog2(PERI_CNT);
  localparam int EW = PW + 1 + SPI_DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = cnt_w(MAX_BYTES_PER_CS);
  localparam int GW = cnt_w(CS_INACTIVE_CYCLES);

  typedef struct packed {
    logic [PW-1:0]             peri;
    logic                      last;
    logic [SPI_DATA_WIDTH-1:0] data;
  } entry_t;

  spi_seq_state_t state, next_state;

  entry_t                    tx_in, head;
  logic                      tx_push, tx_pop, tx_full, tx_empty;
  logic                      rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0]             tx_count, rx_count;
  logic                      unused_cnt;
  logic [BW-1:0]             byte_cnt;
  logic [GW-1:0]             gap_cnt;
  logic [PW-1:0]             cur_peri;
  logic                      cur_last;
  logic [SPI_DATA_WIDTH-1:0] data_q;
  logic [PERI_CNT-1:0]       sel_q, sel_head;
  logic                      can_issue, frame_full, gap_done;

  assign tx_in      = {tx_peri, tx_last, tx_data};
  assign tx_ready   = !tx_full;
  assign tx_push    = tx_valid && tx_ready;
  assign rx_valid   = !rx_empty;
  assign rx_pop     = rx_valid && rx_ready;
  assign unused_cnt = ^{tx_count, rx_count};

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk     (clk),
    .sync_rst(sync_rst),
    .push    (tx_push),
    .pop     (tx_pop),
    .wr_data (tx_in),
    .rd_data (head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  sync_fifo #(.WIDTH(SPI_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk     (clk),
    .sync_rst(sync_rst),
    .push    (rx_push),
    .pop     (rx_pop),
    .wr_data (ctrl_rx_data),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // Only one byte is ever outstanding, so a free RX slot at issue time
  // guarantees the returned byte has somewhere to go.
  assign can_issue  = !tx_empty && (!rx_full || rx_pop);
  assign frame_full = (byte_cnt + BW'(1)) == BW'(MAX_BYTES_PER_CS);
  assign gap_done   = gap_cnt == GW'(CS_INACTIVE_CYCLES - 1);

  // Out-of-range peripheral indices match no bit and leave sel all-ones.
  always_comb begin
    sel_head = '1;
    for (int i = 0; i < PERI_CNT; i++) begin
      sel_head[i] = head.peri != PW'(i);
    end
  end

  always_comb begin
    next_state = state;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    unique case (state)
      IDLE: if (can_issue) next_state = ISSUE;
      ISSUE: begin
        tx_pop     = 1'b1;
        next_state = WAIT;
      end
      WAIT: if (end_txn) begin
        rx_push    = 1'b1;
        next_state = (cur_last || frame_full) ? GAP : HOLD;
      end
      HOLD: if (can_issue) begin
        next_state = (head.peri != cur_peri) ? GAP : ISSUE;
      end
      GAP: if (gap_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Data and sel are loaded on the way into ISSUE so they line up
  // with start_txn; the head is popped at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      cur_peri <= '0;
      cur_last <= 1'b0;
      data_q   <= '0;
      sel_q    <= '1;
    end else begin
      state   <= next_state;
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      if (rx_push) byte_cnt <= byte_cnt + BW'(1);
      if (next_state == IDLE) byte_cnt <= '0;
      if (next_state == ISSUE) begin
        data_q   <= head.data;
        sel_q    <= sel_head;
        cur_peri <= head.peri;
        cur_last <= head.last;
      end
      if (next_state == GAP || next_state == IDLE) sel_q <= '1;
    end
  end

  assign start_txn        = state == ISSUE;
  assign parallel_wr_data = data_q;
  assign p_sel_one_cold   = sel_q;
  assign busy             = (state != IDLE) || !tx_empty;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer: directed and random checks of the SPI sequencer.
// Uses a queue-based transaction/framing model and a simple controller responder.
module tb_spi_txn_sequencer;

  localparam int MB = 2;
  localparam int CI = 1;

  typedef struct packed {
    logic [1:0] peri;
    logic       last;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    logic [3:0] sel;
    int         len;
  } seg_t;

  logic       clk = 1'b0;
  logic       sync_rst = 1'b1;
  logic       tx_valid, tx_ready, tx_last;
  logic [7:0] tx_data;
  logic [1:0] tx_peri;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       start_txn;
  logic [7:0] parallel_wr_data;
  logic [3:0] p_sel_one_cold;
  logic       end_txn;
  logic [7:0] ctrl_rx_data;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  ent_t       exp_tx[$];
  logic [7:0] exp_rx[$];
  seg_t       segs[$];
  int         starts = 0;
  int         man_cnt = 0;
  logic [7:0] man_data = 8'h00;
  bit         man_expect = 1'b0;
  bit         ctrl_en = 1'b0;
  int         rx_mode = 0;

  always #5 clk = ~clk;

  spi_txn_sequencer dut (
    .clk             (clk),
    .sync_rst        (sync_rst),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .tx_peri         (tx_peri),
    .tx_last         (tx_last),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_data         (rx_data),
    .start_txn       (start_txn),
    .parallel_wr_data(parallel_wr_data),
    .p_sel_one_cold  (p_sel_one_cold),
    .end_txn         (end_txn),
    .ctrl_rx_data    (ctrl_rx_data),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rx_ready = (rx_mode == 2) ? 1'($urandom_range(0, 1)) : (rx_mode == 1);
    end
  end

  initial begin
    int served = 0;
    int wait_n = -1;
    end_txn = 1'b0;
    ctrl_rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      end_txn = 1'b0;
      if (man_cnt != served) begin
        served++;
        end_txn = 1'b1;
        ctrl_rx_data = man_data;
        if (man_expect) exp_rx.push_back(man_data);
      end else if (ctrl_en) begin
        if (wait_n > 0) begin
          wait_n--;
          if (wait_n == 0) begin
            end_txn = 1'b1;
            ctrl_rx_data = 8'($urandom);
            exp_rx.push_back(ctrl_rx_data);
            wait_n = -1;
          end
        end else if (start_txn) begin
          wait_n = $urandom_range(1, 4);
        end
      end
    end
  end

  initial begin
    bit         first = 1'b1;
    bit         prev_last = 1'b0;
    bit         prev_start = 1'b0;
    bit         newf;
    int         cnt = 0;
    int         run = 0;
    int         seg_len = 0;
    logic [1:0] prev_peri = 2'd0;
    logic [3:0] seg_sel = 4'hF;
    logic [3:0] exp_sel;
    ent_t       e;
    forever begin
      @(negedge clk);
      if (p_sel_one_cold != seg_sel) begin
        segs.push_back('{seg_sel, seg_len});
        seg_sel = p_sel_one_cold;
        seg_len = 1;
      end else begin
        seg_len++;
      end
      if (sync_rst) begin
        first = 1'b1;
        run = 0;
        prev_start = 1'b0;
      end else begin
        if (start_txn) begin
          starts++;
          check("start_back2back", prev_start, 1'b0);
          check("start_expected", exp_tx.size() > 0, 1'b1);
          if (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            exp_sel = ~(4'b0001 << e.peri);
            check("wr_data", parallel_wr_data, e.data);
            check("sel", p_sel_one_cold, exp_sel);
            newf = first || prev_last || cnt == MB || e.peri != prev_peri;
            check("cs_break", run > 0, newf);
            if (newf && !first) check("cs_gap_len", run >= CI + 1, 1'b1);
            cnt = newf ? 1 : cnt + 1;
            prev_last = e.last;
            prev_peri = e.peri;
            first = 1'b0;
          end
          run = 0;
        end else if (p_sel_one_cold == 4'hF) begin
          run++;
        end
        prev_start = start_txn;
        if (rx_valid && rx_ready) begin
          check("rx_expected", exp_rx.size() > 0, 1'b1);
          if (exp_rx.size() > 0) check("rx_data", rx_data, exp_rx.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    sync_rst = 1'b1;
    exp_tx.delete();
    exp_rx.delete();
    @(posedge clk); #1;
    sync_rst = 1'b0;
    @(negedge clk);
    check("rst_sel", p_sel_one_cold, 4'hF);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_start", start_txn, 1'b0);
    check("rst_wr_data", parallel_wr_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] p, input logic l, input logic [7:0] d);
    int n = 0;
    tx_valid = 1'b1;
    tx_peri = p;
    tx_last = l;
    tx_data = d;
    while (!tx_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 500) check("push_timeout", tx_ready, 1'b1);
    @(posedge clk);
    if (n < 500) exp_tx.push_back({p, l, d});
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (starts < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_starts", starts, n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || exp_rx.size() > 0 || rx_valid) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_busy", busy, 1'b0);
    check("drain_tx_q", exp_tx.size(), 0);
    check("drain_rx_q", exp_rx.size(), 0);
  endtask

  task automatic check_frames(input string tag, input int base,
                              input logic [3:0] s1, input logic [3:0] s2);
    check({tag, "_segs"}, segs.size() >= base + 3, 1'b1);
    if (segs.size() >= base + 3) begin
      check({tag, "_sel1"}, segs[base+1].sel, s1);
      check({tag, "_gap_sel"}, segs[base+2].sel, 4'hF);
      check({tag, "_gap_len"}, segs[base+2].len, CI + 1);
    end
    check({tag, "_sel2"}, p_sel_one_cold, s2);
  endtask

  initial begin
    int base, sbase;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    tx_peri = 2'd0;
    tx_last = 1'b0;

    do_reset();
    push(2'd2, 1'b1, 8'hA5);
    @(negedge clk);
    check("t1_lat_n1", start_txn, 1'b0);
    @(negedge clk);
    check("t1_lat_n2", start_txn, 1'b1);
    check("t1_sel", p_sel_one_cold, 4'b1011);
    check("t1_data", parallel_wr_data, 8'hA5);
    man_data = 8'h3C;
    man_expect = 1'b1;
    man_cnt++;
    @(negedge clk);
    check("t1_wait_sel", p_sel_one_cold, 4'b1011);
    @(negedge clk);
    check("t1_rx_valid", rx_valid, 1'b1);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_gap_sel", p_sel_one_cold, 4'hF);
    check("t1_gap_busy", busy, 1'b1);
    @(negedge clk);
    check("t1_idle_busy", busy, 1'b0);
    rx_mode = 1;
    repeat (3) @(negedge clk);
    check("t1_rx_drained", rx_valid, 1'b0);

    do_reset();
    ctrl_en = 1'b1;
    base = segs.size();
    sbase = starts;
    for (int i = 0; i < 3; i++) push(2'd0, 1'b0, 8'($urandom));
    wait_starts(sbase + 3, 200);
    repeat (6) @(posedge clk);
    #1;
    check_frames("t2", base, 4'b1110, 4'b1110);

    do_reset();
    base = segs.size();
    sbase = starts;
    push(2'd1, 1'b0, 8'($urandom));
    push(2'd3, 1'b0, 8'($urandom));
    wait_starts(sbase + 2, 200);
    repeat (6) @(posedge clk);
    #1;
    check_frames("t3", base, 4'b1101, 4'b0111);

    do_reset();
    rx_mode = 0;
    sbase = starts;
    for (int i = 0; i < 6; i++) push(2'd0, 1'b1, 8'($urandom));
    repeat (60) @(posedge clk);
    #1;
    check("t4_stall_starts", starts - sbase, 4);
    check("t4_rx_valid", rx_valid, 1'b1);
    push(2'd0, 1'b1, 8'($urandom));
    push(2'd0, 1'b1, 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_tx_full", tx_ready, 1'b0);
    end
    check("t4_busy", busy, 1'b1);
    rx_mode = 1;
    wait_idle(1000);
    check("t4_total_starts", starts - sbase, 8);

    do_reset();
    ctrl_en = 1'b0;
    rx_mode = 0;
    sbase = starts;
    push(2'd0, 1'b0, 8'h5A);
    wait_starts(sbase + 1, 20);
    @(negedge clk);
    check("t5_wait_sel", p_sel_one_cold, 4'b1110);
    do_reset();
    man_expect = 1'b0;
    man_data = 8'hEE;
    man_cnt++;
    repeat (4) @(negedge clk);
    check("t5_late_end_rx", rx_valid, 1'b0);
    check("t5_late_end_busy", busy, 1'b0);
    man_cnt++;
    repeat (4) @(negedge clk);
    check("t6_spurious_rx", rx_valid, 1'b0);

    do_reset();
    ctrl_en = 1'b1;
    rx_mode = 2;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      push(2'($urandom), $urandom_range(0, 3) == 0, 8'($urandom));
    end
    push(2'($urandom), 1'b1, 8'($urandom));
    wait_idle(4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
